// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared types and constants for the load/store unit.
//   rv32_lsu_state_t : FSM state encoding (IDLE/REQ/WAIT)
//   LSU_* funct3     : RV32I load/store width/sign encodings
//   rv32_lsu_err_t   : exception codes reported on err_code
//   lsu_check()      : legality/alignment check applied at accept
package rv32_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } rv32_lsu_state_t;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10
  } rv32_lsu_err_t;

  // Illegal funct3 wins over misalignment; alignment is judged on the
  // access size encoded in funct3[1:0].
  function automatic rv32_lsu_err_t lsu_check(input logic       is_load,
                                              input logic [2:0] funct3,
                                              input logic [1:0] off);
    rv32_lsu_err_t res;
    logic          legal;
    res = ERR_NONE;
    if (is_load) legal = (funct3 inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU});
    else         legal = (funct3 inside {LSU_SB, LSU_SH, LSU_SW});
    if (!legal) begin
      res = ERR_ILLEGAL;
    end else if ((funct3[1:0] == 2'b01 && off[0]) ||
                 (funct3[1:0] == 2'b10 && off != 2'b00)) begin
      res = ERR_MISALIGN;
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: word-addressed data-memory port, single outstanding request.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : request from the LSU
//   mem_gnt                                  : memory accepts the request
//   mem_rvalid/mem_rdata                     : read response for a load
// Handshake: a request transfers on a cycle with mem_req & mem_gnt; until
// then the requester holds mem_req and the whole payload stable. A load
// returns exactly one mem_rvalid at least one cycle after its grant; there
// is no back-pressure on the response.
interface rv32_lsu_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/rv32_lsu_align.sv
// rv32_lsu_align: combinational byte-lane logic.
//   st_funct3/st_off/st_data -> st_be/st_wdata : store lane steering
//   ld_funct3/ld_off/ld_rdata -> ld_data       : load extract + extension
// Store and load paths are independent so the store side can work on the
// incoming op while the load side works on the latched one.
module rv32_lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (st_funct3)
      LSU_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      LSU_SH: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      LSU_SW: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0 before extending.
  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      LSU_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_LW:  ld_data = shifted;
      LSU_LBU: ld_data = {24'h0, shifted[7:0]};
      LSU_LHU: ld_data = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// rv32_lsu: load/store unit between EX and writeback.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready + in_*      : op from EX, accepted only in IDLE
//   mem (rv32_lsu_if.master)      : data-memory request/grant/response
//   wb_valid/wb_rd/wb_data        : one-cycle load result pulse
//   st_done                       : one-cycle store complete pulse
//   err_valid/err_code/err_addr   : one-cycle exception pulse
//   dbg_state                     : current FSM state
// Ops are checked at accept; a faulting op never reaches memory.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic [4:0]      in_rd,
  rv32_lsu_if.master      mem,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic            st_done,
  output logic            err_valid,
  output logic [1:0]      err_code,
  output logic [31:0]     err_addr,
  output rv32_lsu_state_t dbg_state
);

  rv32_lsu_state_t   state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [4:0]        rd_q;

  rv32_lsu_err_t     chk;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;

  assign chk = lsu_check(in_is_load, in_funct3, in_addr[1:0]);

  rv32_lsu_align u_align (
    .st_funct3 (in_funct3),
    .st_off    (in_addr[1:0]),
    .st_data   (in_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_off    (addr_q[1:0]),
    .ld_rdata  (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  assign in_ready      = (state == LSU_IDLE);
  assign mem.mem_req   = (state == LSU_REQ);
  // we_q persists after a store, so qualify it with the request.
  assign mem.mem_we    = mem.mem_req & we_q;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      funct3_q  <= 3'b000;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_addr  <= 32'h0;
    end else begin
      wb_valid  <= 1'b0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (in_valid) begin
            if (chk != ERR_NONE) begin
              err_valid <= 1'b1;
              err_code  <= chk;
              err_addr  <= in_addr;
            end else begin
              addr_q   <= in_addr[ADDR_W-1:0];
              wdata_q  <= st_wdata;
              be_q     <= st_be;
              funct3_q <= in_funct3;
              we_q     <= ~in_is_load;
              rd_q     <= in_rd;
              state    <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_gnt) begin
            st_done <= we_q;
            state   <= we_q ? LSU_IDLE : LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (mem.mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ld_data;
            state    <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu: directed and randomized checks of rv32_lsu against a
// byte-level reference model of RV32I load/store semantics.
module tb_rv32_lsu;
  import rv32_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, in_is_load;
  logic [2:0]      in_funct3;
  logic [31:0]     in_addr, in_wdata;
  logic [4:0]      in_rd;
  logic            wb_valid, st_done, err_valid;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data, err_addr;
  logic [1:0]      err_code;
  rv32_lsu_state_t dbg_state;

  rv32_lsu_if #(.ADDR_W(32)) mem_if ();

  rv32_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_rd      (in_rd),
    .mem        (mem_if),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .st_done    (st_done),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  32'(in_ready), 32'd1);
    check({tag, ".mem_req"},   32'(mem_if.mem_req), 32'd0);
    check({tag, ".wb_valid"},  32'(wb_valid), 32'd0);
    check({tag, ".st_done"},   32'(st_done), 32'd0);
    check({tag, ".err_valid"}, 32'(err_valid), 32'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] exp_err(input logic is_load, input logic [2:0] f3,
                                         input logic [31:0] addr);
    bit legal;
    legal = is_load ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    if (!legal) return 2'b10;
    if (addr % op_size(f3) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int o = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + op_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % op_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int     size = op_size(f3);
    int     o    = int'(addr[1:0]);
    longint v    = 0;
    for (int k = 0; k < size; k++) v = v + (longint'(rdata[8*(o+k) +: 8]) << (8*k));
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
      v = v - (longint'(1) << (8*size));
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic check_req(input string tag, input logic is_load, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
    check({tag, ".mem_req"},  32'(mem_if.mem_req), 32'd1);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".mem_we"},   32'(mem_if.mem_we), 32'(!is_load));
    check({tag, ".mem_addr"}, mem_if.mem_addr, addr & 32'hFFFF_FFFC);
    if (!is_load) begin
      check({tag, ".mem_be"},    32'(mem_if.mem_be), 32'(exp_be(f3, addr)));
      check({tag, ".mem_wdata"}, mem_if.mem_wdata, exp_wd(f3, rs2));
    end
  endtask

  // Entered and left at #1 after a clock edge with the LSU idle.
  task automatic do_op(input string tag, input logic is_load, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    logic [1:0] e;
    e = exp_err(is_load, f3, addr);
    in_valid = 1'b1; in_is_load = is_load; in_funct3 = f3;
    in_addr = addr; in_wdata = rs2; in_rd = rd;
    tick();
    in_valid = 1'b0; in_wdata = $urandom; in_addr = $urandom;
    if (e != 2'b00) begin
      check({tag, ".err_valid"}, 32'(err_valid), 32'd1);
      check({tag, ".err_code"},  32'(err_code), 32'(e));
      check({tag, ".err_addr"},  err_addr, addr);
      check({tag, ".no_req"},    32'(mem_if.mem_req), 32'd0);
      check({tag, ".in_ready"},  32'(in_ready), 32'd1);
      tick();
      check_idle({tag, ".after"});
      return;
    end
    for (int i = 0; i < gnt_dly; i++) begin
      check_req(tag, is_load, f3, addr, rs2);
      tick();
    end
    mem_if.mem_gnt = 1'b1;
    check_req(tag, is_load, f3, addr, rs2);
    tick();
    mem_if.mem_gnt = 1'b0;
    if (!is_load) begin
      check({tag, ".st_done"},  32'(st_done), 32'd1);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".mem_req"},  32'(mem_if.mem_req), 32'd0);
    end else begin
      for (int i = 1; i < rv_dly; i++) begin
        check({tag, ".wait_req"},   32'(mem_if.mem_req), 32'd0);
        check({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".wait_wb"},    32'(wb_valid), 32'd0);
        tick();
      end
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = rdata;
      check({tag, ".wb_early"}, 32'(wb_valid), 32'd0);
      tick();
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = $urandom;
      check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({tag, ".wb_rd"},    32'(wb_rd), 32'(rd));
      check({tag, ".wb_data"},  wb_data, exp_ld(f3, addr, rdata));
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    end
    tick();
    check_idle({tag, ".after"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  ld_f3 [5];
    logic        r_ld;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    ld_f3 = '{LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};

    in_valid = 0; in_is_load = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_if.mem_gnt = 0; mem_if.mem_rvalid = 0; mem_if.mem_rdata = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready), 32'd1);
    check("rst.mem_req",   32'(mem_if.mem_req), 32'd0);
    check("rst.mem_we",    32'(mem_if.mem_we), 32'd0);
    check("rst.mem_addr",  mem_if.mem_addr, 32'd0);
    check("rst.mem_be",    32'(mem_if.mem_be), 32'd0);
    check("rst.mem_wdata", mem_if.mem_wdata, 32'd0);
    check("rst.wb_valid",  32'(wb_valid), 32'd0);
    check("rst.wb_rd",     32'(wb_rd), 32'd0);
    check("rst.wb_data",   wb_data, 32'd0);
    check("rst.st_done",   32'(st_done), 32'd0);
    check("rst.err_valid", 32'(err_valid), 32'd0);
    check("rst.err_code",  32'(err_code), 32'd0);
    check("rst.err_addr",  err_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed cases.
    do_op("sw",      1'b0, LSU_SW, 32'h100, 32'hDEADBEEF, 5'd0,  0, 1, 32'h0);
    do_op("sb",      1'b0, LSU_SB, 32'h203, 32'h000000A5, 5'd0,  0, 1, 32'h0);
    do_op("sh",      1'b0, LSU_SH, 32'h302, 32'h1234CAFE, 5'd0,  1, 1, 32'h0);
    do_op("lb",      1'b1, LSU_LB, 32'h301, 32'h0,        5'd3,  0, 1, 32'h00008000);
    do_op("lbu",     1'b1, LSU_LBU,32'h301, 32'h0,        5'd4,  0, 1, 32'h00008000);
    do_op("lh",      1'b1, LSU_LH, 32'h302, 32'h0,        5'd5,  0, 1, 32'h80010000);
    do_op("lhu",     1'b1, LSU_LHU,32'h302, 32'h0,        5'd6,  0, 1, 32'h80010000);
    do_op("lw_rd0",  1'b1, LSU_LW, 32'h400, 32'h0,        5'd0,  0, 1, 32'h89ABCDEF);
    do_op("lw_mis",  1'b1, LSU_LW, 32'h102, 32'h0,        5'd7,  0, 1, 32'h0);
    do_op("lh_mis",  1'b1, LSU_LH, 32'h103, 32'h0,        5'd7,  0, 1, 32'h0);
    do_op("ld_ill",  1'b1, 3'b011, 32'h100, 32'h0,        5'd7,  0, 1, 32'h0);
    do_op("ill_pri", 1'b1, 3'b111, 32'h101, 32'h0,        5'd7,  0, 1, 32'h0);
    do_op("st_ill",  1'b0, 3'b100, 32'h200, 32'h55,       5'd0,  0, 1, 32'h0);
    do_op("lw_slow", 1'b1, LSU_LW, 32'h500, 32'h0,        5'd9,  3, 2, 32'h0BADF00D);

    // Reset while a load waits for its response; a late rvalid is ignored.
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = LSU_LW; in_addr = 32'h600; in_rd = 5'd11;
    tick();
    in_valid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    check("rstw.state", 32'(dbg_state), 32'(LSU_WAIT));
    #2 rst = 1'b1;
    #1;
    check("rstw.in_ready", 32'(in_ready), 32'd1);
    check("rstw.mem_req",  32'(mem_if.mem_req), 32'd0);
    check("rstw.state",    32'(dbg_state), 32'(LSU_IDLE));
    check("rstw.wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h12345678;
    tick();
    mem_if.mem_rvalid = 1'b0;
    check("rstw.stray_wb", 32'(wb_valid), 32'd0);
    tick();
    check_idle("rstw.idle");

    // Randomized mix of legal and faulting ops with variable memory timing.
    for (int n = 0; n < 60; n++) begin
      r_ld = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        r_f3 = r_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
      end
      do_op("rand", r_ld, r_f3, r_addr, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
Load/store unit: the stage directly downstream of the ALU. It takes the ALU-computed effective address (rs1+imm) plus store data and funct3. It drives a single-outstanding word-addressed data-memory request/grant/response interface, performs byte-lane steering, alignment checking and load sign/zero extension, and returns load results to register-file writeback.

Parameters:
ADDR_W, 32, memory address width (mem_addr width; effective address input is always 32b)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  EX presents a memory op
in_ready  output  1  LSU can accept (IDLE)
in_is_load  input  1  1=load, 0=store
in_funct3  input  3  RV32I width/sign field
in_addr  input  32  effective address from ALU res
in_wdata  input  32  store data (rs2)
in_rd  input  5  load destination register
mem_req  output  1  memory request
mem_we  output  1  1=write
mem_addr  output  ADDR_W  word-aligned address
mem_be  output  4  byte enables
mem_wdata  output  32  lane-steered write data
mem_gnt  input  1  request accepted
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word
wb_valid  output  1  one-cycle load-result pulse
wb_rd  output  5  destination register
wb_data  output  32  extended load data
st_done  output  1  one-cycle store-complete pulse
err_valid  output  1  one-cycle exception pulse
err_code  output  2  01 misaligned, 10 illegal funct3
err_addr  output  32  faulting effective address

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except in_ready=1. Latched op cleared. Any in-flight transaction is abandoned; a later mem_rvalid is ignored.
- States: IDLE, REQ, WAIT.
- in_ready = (state==IDLE). Accept = in_valid & in_ready. Latch addr, wdata (steered), be, funct3, is_load, rd.
- Checks at accept, evaluated before any memory access:
  - Illegal funct3: loads 011/110/111, stores >=011 -> err_code=10.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> err_code=01.
  - Illegal takes priority over misaligned.
  - On error: err_valid pulses next cycle with err_addr=in_addr. No mem_req is issued. Stay IDLE.
- IDLE->REQ on a legal accept.
- REQ: mem_req=1 and mem_addr={addr[ADDR_W-1:2],2'b00}. mem_req and its payload stay stable until mem_gnt.
  - mem_gnt & store -> IDLE; st_done pulses the following cycle.
  - mem_gnt & load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid, register wb_data/wb_rd, pulse wb_valid next cycle, -> IDLE. mem_rvalid outside WAIT is ignored. Memory never returns rvalid in the grant cycle.
- Store lanes, with o=addr[1:0]:
  - SB: be=0001<<o, wdata={4{rs2[7:0]}}.
  - SH: be=0011<<o, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Load extract: shift rdata right by 8*o, then:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- A load with rd=0 performs the access; wb_valid still pulses with wb_rd=0.
- Minimum latency, zero-wait memory, accept at cycle T:
  - Store: req+gnt T+1, st_done and in_ready T+2.
  - Load: req+gnt T+1, rvalid T+2, wb_valid T+3, in_ready T+3.
- Back-to-back ops: no accept while busy. Throughput is 1 op per 2 (store) or 3 (load) cycles minimum.

Decomposition:
- rv32_pkg additions:
  - rv32_lsu_state_t enum (IDLE/REQ/WAIT).
  - funct3 constants LSU_LB/LH/LW/LBU/LHU and LSU_SB/SH/SW.
  - rv32_lsu_err_t codes.
- Sub-module rv32_lsu_align: purely combinational store steering (be/wdata) and load extraction/extension, instantiated twice or with separate functions. The FSM stays in rv32_lsu.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, gnt immediate -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF; st_done at T+2.
- SB addr 0x203, rs2 0x000000A5 -> mem_addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x301, rdata 0x00008000 -> wb_data 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x302, rdata 0x80010000 -> 0xFFFF8001.
- LW addr 0x102 -> err_valid, err_code 01, err_addr 0x102, no mem_req. funct3 011 load -> err_code 10.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> mem_req/addr stable throughout, in_ready low, single wb_valid pulse with correct rd.
- rst asserted in WAIT, then stray mem_rvalid -> outputs reset immediately, no wb_valid, in_ready=1.
